// File: rtl/cache_pkg.sv
// Shared state encoding and default widths for the cache controller and cache array.
package cache_pkg;

  localparam int CACHE_ADDR_W = 8;
  localparam int CACHE_DATA_W = 8;
  localparam int CACHE_CNT_W  = 16;

  // One-hot encoding: any other pattern is illegal and decodes to no active output.
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_LOOKUP = 6'b000010,
    ST_MEM_RD = 6'b000100,
    ST_FILL   = 6'b001000,
    ST_MEM_WR = 6'b010000,
    ST_RESP   = 6'b100000
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: read-allocate / write-through-no-allocate sequencing between CPU, array and memory.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_ADDR_W,
  parameter int DATA_WIDTH = CACHE_DATA_W
`ifdef CACHE_CTRL_STATS_EN
  ,
  parameter int CNT_WIDTH  = CACHE_CNT_W
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic [ADDR_WIDTH-1:0] c_addr,
  input  logic                  c_hit,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  c_fill,
  output logic                  c_update,
  output logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_hits,
  output logic [CNT_WIDTH-1:0]  stat_misses
`endif
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (we_q) begin
          // Writes echo their own data back on the acknowledge.
          rdata_d = wdata_q;
          state_d = ST_MEM_WR;
        end else if (c_hit) begin
          rdata_d = c_rdata;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = ST_FILL;
        end
      end
      ST_FILL:   state_d = ST_RESP;
      ST_MEM_WR: begin
        if (mem_ack) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state and latches only; c_update alone depends on the array's hit.
  assign cpu_ack   = (state_q == ST_RESP);
  assign cpu_rdata = rdata_q;
  assign c_addr    = addr_q;
  assign c_fill    = (state_q == ST_FILL);
  assign c_update  = (state_q == ST_LOOKUP) && we_q && c_hit;
  assign c_wdata   = (state_q == ST_FILL) ? rdata_q : wdata_q;
  assign mem_req   = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign mem_we    = (state_q == ST_MEM_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  logic lookup;
  assign lookup = (state_q == ST_LOOKUP);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hits (
    .clk   (clk),
    .rst   (rst),
    .inc   (lookup && c_hit),
    .clr   (1'b0),
    .count (stat_hits)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_misses (
    .clk   (clk),
    .rst   (rst),
    .inc   (lookup && !c_hit),
    .clr   (1'b0),
    .count (stat_misses)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic [7:0] c_addr;
  logic       c_hit;
  logic [7:0] c_rdata;
  logic       c_fill;
  logic       c_update;
  logic [7:0] c_wdata;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       model_ack = 1'b0;
  logic       stray_ack = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
  logic [1:0] stat_hits;
  logic [1:0] stat_misses;
`endif

  always #5 clk = ~clk;

  assign mem_ack = model_ack | stray_ack;

`ifdef CACHE_CTRL_STATS_EN
  cache_ctrl #(.CNT_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .c_addr      (c_addr),
    .c_hit       (c_hit),
    .c_rdata     (c_rdata),
    .c_fill      (c_fill),
    .c_update    (c_update),
    .c_wdata     (c_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );
`else
  cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .c_addr    (c_addr),
    .c_hit     (c_hit),
    .c_rdata   (c_rdata),
    .c_fill    (c_fill),
    .c_update  (c_update),
    .c_wdata   (c_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fill_cnt = 0;
  int upd_cnt = 0;
  int memtx_cnt = 0;
  int mem_delay = 0;

  typedef struct {
    logic [7:0] rdata;
    int         lat;
    int         start;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  logic       cv [4];
  logic [7:0] ca [4];
  logic [7:0] cd [4];
  int         cptr = 0;

  always_comb begin
    c_hit   = 1'b0;
    c_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (cv[i] && ca[i] == c_addr) begin
        c_hit   = 1'b1;
        c_rdata = cd[i];
      end
    end
  end

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4; i++) cv[i] <= 1'b0;
      cptr <= 0;
    end else begin
      if (c_fill) begin
        cv[cptr] <= 1'b1;
        ca[cptr] <= c_addr;
        cd[cptr] <= c_wdata;
        cptr     <= (cptr + 1) % 4;
      end
      if (c_update) begin
        for (int i = 0; i < 4; i++) begin
          if (cv[i] && ca[i] == c_addr) cd[i] <= c_wdata;
        end
      end
    end
  end

  logic [7:0] mem_model [256];
  int         wcnt = 0;
  assign mem_rdata = mem_model[mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5A;
    mem_model[8'h42] = 8'hA5;
    mem_model[8'h77] = 8'h5E;
    forever begin
      @(negedge clk);
      if (model_ack) begin
        model_ack = 1'b0;
      end else if (mem_req) begin
        if (wcnt >= mem_delay) begin
          model_ack = 1'b1;
          memtx_cnt++;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (c_fill) fill_cnt++;
      if (c_update) upd_cnt++;
      if (cpu_ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ack: cpu_ack=1 at cycle %0d with no request outstanding", cyc);
        end else begin
          e = sb.pop_front();
          checks += 2;
          if (cpu_rdata !== e.rdata) begin
            failures++;
            $display("FAIL rdata: got 0x%02h expected 0x%02h", cpu_rdata, e.rdata);
          end
          if ((cyc - e.start) != e.lat) begin
            failures++;
            $display("FAIL latency: got %0d expected %0d", cyc - e.start, e.lat);
          end
          $display("ack cycle=%0d rdata=0x%02h lat=%0d", cyc, cpu_rdata, cyc - e.start);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] ed, input int lat, input int dly);
    exp_t e;
    int   n;
    @(negedge clk);
    mem_delay = dly;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    e.rdata   = ed;
    e.lat     = lat;
    e.start   = cyc;
    sb.push_back(e);
    $display("req we=%0b addr=0x%02h wdata=0x%02h exp=0x%02h lat=%0d", we, a, wd, ed, lat);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (cpu_ack || n >= 40) break;
      if (n == 0) begin
        cpu_we    = ~we;
        cpu_addr  = ~a;
        cpu_wdata = ~wd;
      end
      n++;
    end
    cpu_req = 1'b0;
    if (!cpu_ack) begin
      checks++;
      failures++;
      $display("FAIL timeout: no cpu_ack for addr 0x%02h", a);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int f0, u0, m0, n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", int'(cpu_ack), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_c_fill", int'(c_fill), 0);
    chk("rst_c_update", int'(c_update), 0);
    chk("rst_c_addr", int'(c_addr), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_cpu_rdata", int'(cpu_rdata), 0);
    rst = 1'b1;
    @(negedge clk);

    f0 = fill_cnt; m0 = memtx_cnt;
    do_req(1'b0, 8'h42, 8'h00, 8'hA5, 7, 3);
    chk("miss_fill_pulses", fill_cnt - f0, 1);
    chk("miss_mem_tx", memtx_cnt - m0, 1);
    m0 = memtx_cnt;
    do_req(1'b0, 8'h42, 8'h00, 8'hA5, 2, 0);
    chk("hit_no_mem", memtx_cnt - m0, 0);

    u0 = upd_cnt; f0 = fill_cnt;
    do_req(1'b1, 8'h42, 8'h3C, 8'h3C, 3, 0);
    chk("wr_hit_update", upd_cnt - u0, 1);
    chk("wr_hit_no_fill", fill_cnt - f0, 0);
    chk("wr_hit_mem_data", int'(mem_model[8'h42]), 8'h3C);
    do_req(1'b0, 8'h42, 8'h00, 8'h3C, 2, 0);

    u0 = upd_cnt; f0 = fill_cnt;
    do_req(1'b1, 8'h10, 8'h99, 8'h99, 5, 2);
    chk("wr_miss_no_update", upd_cnt - u0, 0);
    chk("wr_miss_no_fill", fill_cnt - f0, 0);
    chk("wr_miss_mem_data", int'(mem_model[8'h10]), 8'h99);
    m0 = memtx_cnt;
    do_req(1'b0, 8'h10, 8'h00, 8'h99, 4, 0);
    chk("rd_after_wr_miss", memtx_cnt - m0, 1);

    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk("stray_mem_req", int'(mem_req), 0);
    @(negedge clk);
    chk("stray_cpu_ack", int'(cpu_ack), 0);
    do_req(1'b0, 8'h10, 8'h00, 8'h99, 2, 0);
    do_req(1'b0, 8'h20, 8'h00, 8'h7A, 4, 0);

    @(negedge clk);
    mem_delay = 10;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h77;
    cpu_req   = 1'b1;
    $display("req we=0 addr=0x77 aborted by reset");
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_mem_rd", int'(mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_req_drop", int'(mem_req), 0);
    chk("abort_no_ack", int'(cpu_ack), 0);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    f0 = fill_cnt;
    do_req(1'b0, 8'h77, 8'h00, 8'h5E, 5, 1);
    chk("post_rst_fill", fill_cnt - f0, 1);

    for (int i = 0; i < 5; i++) do_req(1'b0, 8'h42, 8'h00, 8'h3C, 2, 0);
`ifdef CACHE_CTRL_STATS_EN
    chk("stat_hits_sat", int'(stat_hits), 3);
    chk("stat_misses", int'(stat_misses), 1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
